// File: rtl/aes_pkg.sv
// Shared AES types, S-box/Rcon tables, byte/word helpers and FSM state codes.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package aes_pkg;

  // Byte, word, 4x4 state (element [15] is state byte 0, the MSB) and round key
  typedef logic [7:0]       byte_t;
  typedef logic [31:0]      word_t;
  typedef logic [15:0][7:0] state_t;
  typedef logic [127:0]     rkey_t;

  // Controller states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_KEY_EXP = 3'd1;
  localparam logic [2:0] ST_READY   = 3'd2;
  localparam logic [2:0] ST_ROUND   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam byte_t SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic byte_t sbox(input byte_t x);
    return SBOX[x];
  endfunction

  // Multiply by x in GF(2^8), reduced modulo 0x11B
  function automatic byte_t xtime(input byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic word_t rot_word(input word_t x);
    return {x[23:0], x[31:24]};
  endfunction

  function automatic word_t sub_word(input word_t x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  // Round constant table; entries past 10 are never reached for legal key sizes
  function automatic byte_t rcon(input logic [5:0] n);
    byte_t v;
    case (n)
      6'd1:    v = 8'h01;
      6'd2:    v = 8'h02;
      6'd3:    v = 8'h04;
      6'd4:    v = 8'h08;
      6'd5:    v = 8'h10;
      6'd6:    v = 8'h20;
      6'd7:    v = 8'h40;
      6'd8:    v = 8'h80;
      6'd9:    v = 8'h1b;
      6'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/aes_cipher_iter_round.sv
// AES round transforms: SubBytes, ShiftRows, MixColumns, AddRoundKey (one module each).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller registers the result.
module subBytes
  import aes_pkg::*;
(
  input  logic [127:0] i_st,
  output logic [127:0] o_st
);
  // Byte position does not matter for a byte-wise substitution
  for (genvar k = 0; k < 16; k++) begin : g_byte
    assign o_st[8*k +: 8] = sbox(i_st[8*k +: 8]);
  end
endmodule

module shiftRows
  import aes_pkg::*;
(
  input  logic [127:0] i_st,
  output logic [127:0] o_st
);
  state_t w_in;
  state_t w_out;
  assign w_in = i_st;
  assign o_st = w_out;
  // Byte r+4c is row r, column c; row r rotates left by r columns
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign w_out[15 - (r + 4*c)] = w_in[15 - (r + 4*((c + r) % 4))];
    end
  end
endmodule

module mixColumns
  import aes_pkg::*;
(
  input  logic [127:0] i_st,
  output logic [127:0] o_st
);
  state_t w_in;
  state_t w_out;
  assign w_in = i_st;
  assign o_st = w_out;
  for (genvar c = 0; c < 4; c++) begin : g_col
    byte_t w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = w_in[15 - 4*c];
    assign w_a1 = w_in[14 - 4*c];
    assign w_a2 = w_in[13 - 4*c];
    assign w_a3 = w_in[12 - 4*c];
    // Fixed matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2]
    assign w_out[15 - 4*c] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
    assign w_out[14 - 4*c] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
    assign w_out[13 - 4*c] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
    assign w_out[12 - 4*c] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
  end
endmodule

module addRoundKey
  import aes_pkg::*;
(
  input  logic [127:0] i_st,
  input  logic [127:0] i_rk,
  output logic [127:0] o_st
);
  rkey_t w_rk;
  assign w_rk = i_rk;
  assign o_st = i_st ^ w_rk;
endmodule

// File: rtl/aes_key_word.sv
// Next key-schedule word: w[i] = w[i-NK] ^ f(w[i-1]) for word index i.
// Latency: combinational, zero cycles.
// Backpressure: none; written into the key store by the caller.
module aes_key_word
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic [31:0] i_w_nk,
  input  logic [31:0] i_w_prev,
  input  logic [5:0]  i_idx,
  output logic [31:0] o_w
);
  logic [5:0] w_mod;
  logic [5:0] w_div;
  word_t      w_f;

  assign w_mod = i_idx % 6'(NK);
  assign w_div = i_idx / 6'(NK);

  // Select the word transform by position within the key-length period
  always_comb begin
    w_f = i_w_prev;
    if (w_mod == 6'd0) begin
      w_f = sub_word(rot_word(i_w_prev)) ^ {rcon(w_div), 24'h000000};
    end else if (NK == 8 && w_mod == 6'd4) begin
      w_f = sub_word(i_w_prev);
    end
  end

  assign o_w = i_w_nk ^ w_f;
endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128/192/256 encryptor: stores the expanded key, one round per clock.
// Latency: plaintext accepted in cycle c gives out_valid in cycle c+NR+1; key expansion NW-NK cycles.
// Backpressure: result held in DONE until out_ready; key/in ready only in IDLE/READY, never from out_ready.
module aes_cipher_iter
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_key_valid,
  output logic              o_key_ready,
  input  logic [32*NK-1:0]  i_key,
  output logic              o_key_ok,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [127:0]      i_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [127:0]      o_o
);
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $error("aes_cipher_iter: NK must be 4, 6 or 8");
  end

  logic [2:0]   r_state;
  logic         r_key_ok;
  logic         r_out_valid;
  logic [127:0] r_st;
  logic [3:0]   r_round;
  logic [5:0]   r_widx;
  logic [31:0]  r_w [0:NW-1];

  logic         w_in_round;
  logic         w_last_round;
  logic         w_key_load;
  logic [3:0]   w_rk_round;
  logic [5:0]   w_rk_base;
  rkey_t        w_rk;
  logic [127:0] w_sb;
  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [127:0] w_ark_in;
  logic [127:0] w_ark;
  logic [31:0]  w_new_word;

  assign o_key_ready = (r_state == ST_IDLE) || (r_state == ST_READY);
  assign o_in_ready  = (r_state == ST_READY) && !i_key_valid;
  assign o_key_ok    = r_key_ok;
  assign o_out_valid = r_out_valid;
  assign o_o         = r_st;

  assign w_key_load   = o_key_ready && i_key_valid;
  assign w_in_round   = (r_state == ST_ROUND);
  assign w_last_round = (r_round == 4'(NR));

  // Round-key read port: rk[0] for the initial whitening, rk[r] during rounds
  assign w_rk_round = w_in_round ? r_round : 4'd0;
  assign w_rk_base  = {w_rk_round, 2'b00};
  assign w_rk = {r_w[w_rk_base], r_w[w_rk_base + 6'd1],
                 r_w[w_rk_base + 6'd2], r_w[w_rk_base + 6'd3]};

  subBytes   u_sub_bytes   (.i_st(r_st), .o_st(w_sb));
  shiftRows  u_shift_rows  (.i_st(w_sb), .o_st(w_sr));
  mixColumns u_mix_columns (.i_st(w_sr), .o_st(w_mc));

  // The final round skips MixColumns; outside rounds the key adder whitens new plaintext
  assign w_ark_in = w_in_round ? (w_last_round ? w_sr : w_mc) : i_data;

  addRoundKey u_add_round_key (.i_st(w_ark_in), .i_rk(w_rk), .o_st(w_ark));

  aes_key_word #(.NK(NK)) u_key_word (
    .i_w_nk   (r_w[r_widx - 6'(NK)]),
    .i_w_prev (r_w[r_widx - 6'd1]),
    .i_idx    (r_widx),
    .o_w      (w_new_word)
  );

  // Key store: load the raw key words, then append one expanded word per cycle
  always_ff @(posedge i_clk) begin
    if (w_key_load) begin
      for (int k = 0; k < NK; k++) begin
        r_w[k] <= i_key[32*(NK-1-k) +: 32];
      end
    end else if (r_state == ST_KEY_EXP) begin
      r_w[r_widx] <= w_new_word;
    end
  end

  // Controller: key expansion, round sequencing and output hold
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_key_ok    <= 1'b0;
      r_out_valid <= 1'b0;
      r_st        <= '0;
      r_round     <= 4'd0;
      r_widx      <= 6'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_key_valid) begin
            r_widx  <= 6'(NK);
            r_state <= ST_KEY_EXP;
          end
        end
        ST_KEY_EXP: begin
          r_widx <= r_widx + 6'd1;
          if (r_widx == 6'(NW - 1)) begin
            r_key_ok <= 1'b1;
            r_state  <= ST_READY;
          end
        end
        ST_READY: begin
          // A new key wins over plaintext; the schedule is invalid until re-expanded
          if (i_key_valid) begin
            r_key_ok <= 1'b0;
            r_widx   <= 6'(NK);
            r_state  <= ST_KEY_EXP;
          end else if (i_in_valid) begin
            r_st    <= w_ark;
            r_round <= 4'd1;
            r_state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          r_st <= w_ark;
          if (w_last_round) begin
            r_round     <= 4'd0;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_round <= r_round + 4'd1;
          end
        end
        ST_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_READY;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed bench for aes_cipher_iter with FIPS-197 vectors on NK=4/6/8 instances.
// Inputs change and outputs are sampled 1-2 ns after the rising edge.
// Covers stall without key, key/data collision, output backpressure and reset abort.
module tb_aes_cipher_iter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         out_ready;
  logic [127:0] data;

  logic         kv4, kr4, ok4, iv4, ir4, ov4;
  logic [127:0] key4, o4;
  logic         kv6, kr6, ok6, iv6, ir6, ov6;
  logic [191:0] key6;
  logic [127:0] o6;
  logic         kv8, kr8, ok8, iv8, ir8, ov8;
  logic [255:0] key8;
  logic [127:0] o8;

  aes_cipher_iter #(.NK(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_key_valid(kv4), .o_key_ready(kr4), .i_key(key4),
    .o_key_ok(ok4), .i_in_valid(iv4), .o_in_ready(ir4), .i_data(data),
    .o_out_valid(ov4), .i_out_ready(out_ready), .o_o(o4));
  aes_cipher_iter #(.NK(6)) dut6 (
    .i_clk(clk), .i_rst(rst), .i_key_valid(kv6), .o_key_ready(kr6), .i_key(key6),
    .o_key_ok(ok6), .i_in_valid(iv6), .o_in_ready(ir6), .i_data(data),
    .o_out_valid(ov6), .i_out_ready(out_ready), .o_o(o6));
  aes_cipher_iter #(.NK(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_key_valid(kv8), .o_key_ready(kr8), .i_key(key8),
    .o_key_ok(ok8), .i_in_valid(iv8), .o_in_ready(ir8), .i_data(data),
    .o_out_valid(ov8), .i_out_ready(out_ready), .o_o(o8));

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C8 = 128'h8ea2b7ca516745bfeafc49904b496089;

  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer a key to the NK=4 core; key_ok must rise 40 edges after the accepting edge
  task automatic load_key4(input logic [127:0] k, input string tag);
    int n;
    key4 = k;
    kv4  = 1'b1;
    n = 0;
    while (!kr4 && n < 100) begin step(); n++; end
    step();
    kv4 = 1'b0;
    #1;
    chk({tag, " expansion ready lines"}, 128'({kr4, ir4}), 128'd0);
    n = 0;
    while (!ok4 && n < 200) begin step(); n++; end
    chk({tag, " key_ok latency"}, 128'(n), 128'd40);
  endtask

  // Encrypt one block on the NK=4 core with out_ready high; lat counts edges after accept
  task automatic enc4(input logic [127:0] d, output logic [127:0] res, output int lat);
    int n;
    data = d;
    iv4  = 1'b1;
    #1;
    n = 0;
    while (!ir4 && n < 200) begin step(); #1; n++; end
    step();
    iv4 = 1'b0;
    lat = 0;
    while (!ov4 && lat < 200) begin step(); lat++; end
    res = o4;
    step();
  endtask

  initial begin
    logic [127:0] res;
    int lat, n, stable;
    rst = 1'b1; out_ready = 1'b1; data = '0;
    kv4 = 1'b0; iv4 = 1'b0; key4 = '0;
    kv6 = 1'b0; iv6 = 1'b0; key6 = '0;
    kv8 = 1'b0; iv8 = 1'b0; key8 = '0;
    step(); step();

    // Reset state
    chk("reset key_ok", 128'(ok4), 128'd0);
    chk("reset out_valid", 128'(ov4), 128'd0);
    chk("reset o", o4, 128'd0);
    chk("reset key_ready/in_ready", 128'({kr4, ir4}), 128'b10);
    rst = 1'b0;
    step();

    // Plaintext offered with no key: must stall
    data = P1; iv4 = 1'b1;
    stable = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ir4 === 1'b0 && ov4 === 1'b0) stable++;
    end
    chk("no-key stall", 128'(stable), 128'd5);

    // T1: the stalled block proceeds once the key schedule is ready
    load_key4(K1, "T1");
    enc4(P1, res, lat);
    chk("T1 ciphertext", res, C1);
    chk("T1 latency", 128'(lat), 128'd10);

    // T5: key and data together in READY -> key wins, data waits, then uses the new key
    key4 = K2; kv4 = 1'b1; data = P2; iv4 = 1'b1;
    #1;
    chk("T5 collision in_ready", 128'(ir4), 128'd0);
    chk("T5 collision key_ready", 128'(kr4), 128'd1);
    step();
    kv4 = 1'b0;
    #1;
    chk("T5 data stalled", 128'({ir4, ov4}), 128'd0);
    n = 0;
    while (!ok4 && n < 200) begin step(); n++; end
    chk("T5 key_ok latency", 128'(n), 128'd40);
    enc4(P2, res, lat);
    chk("T2 ciphertext", res, C2);
    chk("T2 latency", 128'(lat), 128'd10);

    // T4: output backpressure for 20 cycles with the next block already offered
    out_ready = 1'b0; data = P2; iv4 = 1'b1;
    #1;
    chk("T4 in_ready before", 128'(ir4), 128'd1);
    step();
    lat = 0;
    while (!ov4 && lat < 200) begin step(); lat++; end
    chk("T4 latency", 128'(lat), 128'd10);
    chk("T4 ciphertext", o4, C2);
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ov4 === 1'b1 && o4 === C2 && ir4 === 1'b0 && kr4 === 1'b0) stable++;
    end
    chk("T4 hold stable", 128'(stable), 128'd20);
    out_ready = 1'b1;
    step();
    chk("T4 released out_valid", 128'(ov4), 128'd0);
    chk("T4 next accept ready", 128'(ir4), 128'd1);
    step();
    iv4 = 1'b0;
    lat = 0;
    while (!ov4 && lat < 200) begin step(); lat++; end
    chk("T4 second latency", 128'(lat), 128'd10);
    chk("T4 second ciphertext", o4, C2);
    step();

    // T6: reset while round counter is 5 aborts the block and drops the key
    data = P1; iv4 = 1'b1;
    #1;
    step();
    iv4 = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("T6 key_ok after rst", 128'(ok4), 128'd0);
    chk("T6 ready lines after rst", 128'({kr4, ir4}), 128'b10);
    iv4 = 1'b1;
    stable = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (ov4 === 1'b0 && ir4 === 1'b0 && ok4 === 1'b0) stable++;
    end
    chk("T6 no output, input ignored", 128'(stable), 128'd15);
    load_key4(K1, "T6 reload");
    enc4(P1, res, lat);
    chk("T6 ciphertext after reload", res, C1);

    // T3: AES-192
    for (int b = 0; b < 24; b++) key6[191 - 8*b -: 8] = 8'(b);
    kv6 = 1'b1;
    #1;
    chk("T3-192 key_ready", 128'(kr6), 128'd1);
    step();
    kv6 = 1'b0;
    n = 0;
    while (!ok6 && n < 200) begin step(); n++; end
    chk("T3-192 key_ok latency", 128'(n), 128'd46);
    data = P2; iv6 = 1'b1;
    #1;
    chk("T3-192 in_ready", 128'(ir6), 128'd1);
    step();
    iv6 = 1'b0;
    lat = 0;
    while (!ov6 && lat < 200) begin step(); lat++; end
    chk("T3-192 latency", 128'(lat), 128'd12);
    chk("T3-192 ciphertext", o6, C6);

    // T3: AES-256
    for (int b = 0; b < 32; b++) key8[255 - 8*b -: 8] = 8'(b);
    kv8 = 1'b1;
    #1;
    chk("T3-256 key_ready", 128'(kr8), 128'd1);
    step();
    kv8 = 1'b0;
    n = 0;
    while (!ok8 && n < 200) begin step(); n++; end
    chk("T3-256 key_ok latency", 128'(n), 128'd52);
    data = P2; iv8 = 1'b1;
    #1;
    chk("T3-256 in_ready", 128'(ir8), 128'd1);
    step();
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 200) begin step(); lat++; end
    chk("T3-256 latency", 128'(lat), 128'd14);
    chk("T3-256 ciphertext", o8, C8);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end
endmodule
